// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - request/response bus between a load/store unit and data_memory_ctrl
//
// Purpose: groups the request and response handshake signals of the data memory
// controller. Signal suffixes are seen from the controller: *_i are driven by the
// requester (master), *_o by the controller (slave).
//
// Signals:
//   req_valid_i   request present
//   req_ready_o   controller accepts a request this cycle
//   req_we_i      1 = store, 0 = load
//   req_funct3_i  RV32 load/store funct3
//   req_addr_i    byte address
//   req_wdata_i   store data, right-aligned
//   rsp_valid_o   response present
//   rsp_ready_i   consumer takes the response
//   rsp_rdata_o   extended load data (0 for stores and errors)
//   rsp_err_o     access fault, qualified by rsp_valid_o
interface data_memory_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [2:0]            req_funct3_i;
  logic [DATA_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - single-outstanding RV32 data memory controller over a byte-lane block RAM
//
// Purpose: accepts one load/store at a time, commits stores with byte enables at
// the accept edge, returns sign/zero-extended load data after 1 + WAIT_STATES
// cycles and holds the response until it is taken.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset (memory contents are not reset)
//   bus    data_memory_ctrl_if.slave request/response handshake
//
// Parameters:
//   DEPTH        number of 32-bit words (power of 2, >= 4)
//   WAIT_STATES  extra cycles between accept and response (0..7)
//
// Build option: define DMEM_MISALIGN_CHECK_EN to fault misaligned halfword/word
// accesses; without it the low address bits below the access size are ignored.
`ifndef DATA_MEM_DEPTH
`define DATA_MEM_DEPTH 1024
`endif

module data_memory_ctrl #(
  parameter int DEPTH       = `DATA_MEM_DEPTH,
  parameter int WAIT_STATES = 1
) (
  input logic               clk,
  input logic               rst_n,
  data_memory_ctrl_if.slave bus
);
  localparam int         LP_AW        = $clog2(DEPTH);
  localparam logic [2:0] LP_LAST_WAIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_wait_cnt, w_wait_cnt_nxt;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [1:0]         r_addr_lo;
  logic [LP_AW-1:0]   r_word_idx;
  logic               r_err;
  logic [31:0]        r_rd_word;
  logic [31:0]        r_mem [DEPTH];

  logic               w_accept;
  logic               w_oor;
  logic               w_bad_f3;
  logic               w_misalign;
  logic               w_err;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata_rep;
  logic [LP_AW-1:0]   w_req_idx;
  logic [LP_AW-1:0]   w_rd_idx;
  logic               w_rd_en;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load_data;

  // Ready is masked while reset is held so no store can slip into the RAM then.
  assign bus.req_ready_o = (r_state == ST_IDLE) && rst_n;
  assign w_accept        = bus.req_valid_i && bus.req_ready_o;
  assign w_req_idx       = bus.req_addr_i[LP_AW+1:2];
  assign w_oor           = (bus.req_addr_i >> (LP_AW + 2)) != '0;

  always_comb begin
    w_bad_f3 = 1'b1;
    if (bus.req_we_i) begin
      case (bus.req_funct3_i)
        F3_B, F3_H, F3_W: w_bad_f3 = 1'b0;
        default:          w_bad_f3 = 1'b1;
      endcase
    end else begin
      case (bus.req_funct3_i)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: w_bad_f3 = 1'b0;
        default:                        w_bad_f3 = 1'b1;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_misalign = ((bus.req_funct3_i[1:0] == 2'b01) && bus.req_addr_i[0]) ||
                      ((bus.req_funct3_i[1:0] == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = w_oor || w_bad_f3 || w_misalign;

  // Lane select and data replication; enables are cleared unless a clean store is accepted.
  always_comb begin
    w_be        = 4'b0000;
    w_wdata_rep = bus.req_wdata_i;
    case (bus.req_funct3_i[1:0])
      2'b00: begin
        w_be        = 4'b0001 << bus.req_addr_i[1:0];
        w_wdata_rep = {4{bus.req_wdata_i[7:0]}};
      end
      2'b01: begin
        w_be        = bus.req_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{bus.req_wdata_i[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
    if (!(w_accept && bus.req_we_i && !w_err)) begin
      w_be = 4'b0000;
    end
  end

  // The RAM read lands on the edge that enters RESP: the accept edge itself when
  // there are no wait states, otherwise the last WAIT edge.
  assign w_rd_idx = (r_state == ST_IDLE) ? w_req_idx : r_word_idx;
  assign w_rd_en  = (r_state == ST_IDLE) ? (w_accept && (WAIT_STATES == 0))
                                         : ((r_state == ST_WAIT) && (r_wait_cnt == LP_LAST_WAIT));

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) begin
        r_mem[w_req_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
      end
    end
    if (w_rd_en) begin
      r_rd_word <= r_mem[w_rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 3'd0;
      r_we       <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr_lo  <= 2'd0;
      r_word_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_accept) begin
        r_we       <= bus.req_we_i;
        r_funct3   <= bus.req_funct3_i;
        r_addr_lo  <= bus.req_addr_i[1:0];
        r_word_idx <= w_req_idx;
        r_err      <= w_err;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_wait_cnt_nxt = 3'd0;
          w_state_nxt    = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == LP_LAST_WAIT) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 3'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Load alignment/extension works on the held RAM word, so the response stays
  // stable for as long as RESP lasts.
  assign w_byte = r_rd_word[{r_addr_lo, 3'b000} +: 8];
  assign w_half = r_addr_lo[1] ? r_rd_word[31:16] : r_rd_word[15:0];

  always_comb begin
    w_load_data = r_rd_word;
    case (r_funct3)
      F3_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   w_load_data = {24'd0, w_byte};
      F3_H:    w_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   w_load_data = {16'd0, w_half};
      default: w_load_data = r_rd_word;
    endcase
  end

  assign bus.rsp_valid_o = (r_state == ST_RESP);
  assign bus.rsp_err_o   = bus.rsp_valid_o && r_err;
  assign bus.rsp_rdata_o = (bus.rsp_valid_o && !r_err && !r_we) ? w_load_data : 32'd0;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - self-checking bench for data_memory_ctrl
module tb_data_memory_ctrl;
  localparam int DEPTH = 1024;
  localparam int WS    = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_ctrl_if #(.DATA_WIDTH(32)) u_bus ();

  data_memory_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  // Reference model: flat byte-addressed memory plus the access rules.
  logic [7:0]  mb [4*DEPTH];
  bit          pending = 1'b0;
  bit          was_pending;
  bit          exp_v;
  int          due = 0;
  logic [31:0] m_rd;
  logic        m_err;

  task automatic model_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int a, hb, wb;
    rd  = 32'd0;
    err = 1'b0;
    if (addr >= 32'(4*DEPTH)) err = 1'b1;
    if (we) begin
      if (!(f3 inside {3'd0, 3'd1, 3'd2})) err = 1'b1;
    end else begin
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) err = 1'b1;
    end
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((f3[1:0] == 2'd1) && addr[0]) err = 1'b1;
    if ((f3[1:0] == 2'd2) && (addr[1:0] != 2'd0)) err = 1'b1;
`endif
    if (!err) begin
      a  = int'(addr);
      hb = a - (a % 2);
      wb = a - (a % 4);
      if (we) begin
        case (f3)
          3'd0: mb[a] = wd[7:0];
          3'd1: begin mb[hb] = wd[7:0]; mb[hb+1] = wd[15:8]; end
          default: for (int k = 0; k < 4; k++) mb[wb+k] = wd[8*k +: 8];
        endcase
      end else begin
        case (f3)
          3'd0: rd = {{24{mb[a][7]}}, mb[a]};
          3'd4: rd = {24'd0, mb[a]};
          3'd1: rd = {{16{mb[hb+1][7]}}, mb[hb+1], mb[hb]};
          3'd5: rd = {16'd0, mb[hb+1], mb[hb]};
          default: rd = {mb[wb+3], mb[wb+2], mb[wb+1], mb[wb]};
        endcase
      end
    end
  endtask

  // Every-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (!rst_n) begin
        pending = 1'b0;
        chk("reset rsp_valid", {31'd0, u_bus.rsp_valid_o}, 32'd0);
        chk("reset rsp_rdata", u_bus.rsp_rdata_o, 32'd0);
        chk("reset rsp_err", {31'd0, u_bus.rsp_err_o}, 32'd0);
      end else begin
        was_pending = pending;
        chk("req_ready", {31'd0, u_bus.req_ready_o}, {31'd0, !was_pending});
        exp_v = was_pending && (cyc >= due);
        chk("rsp_valid", {31'd0, u_bus.rsp_valid_o}, {31'd0, exp_v});
        if (exp_v) begin
          chk("rsp_rdata", u_bus.rsp_rdata_o, m_rd);
          chk("rsp_err", {31'd0, u_bus.rsp_err_o}, {31'd0, m_err});
          if (u_bus.rsp_ready_i) pending = 1'b0;
        end
        if (!was_pending && u_bus.req_valid_i) begin
          model_txn(u_bus.req_we_i, u_bus.req_funct3_i, u_bus.req_addr_i, u_bus.req_wdata_i, m_rd, m_err);
          pending = 1'b1;
          due     = cyc + 1 + WS;
        end
      end
    end
  end

  // One transaction with hand-computed expectations; hold > 0 keeps rsp_ready_i low
  // and offers a competing store to the same address while the response waits.
  task automatic txn(input string name, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold, input logic [31:0] exp_rd, input logic exp_err);
    int n, acc;
    @(posedge clk); #1;
    u_bus.req_valid_i  = 1'b1;
    u_bus.req_we_i     = we;
    u_bus.req_funct3_i = f3;
    u_bus.req_addr_i   = addr;
    u_bus.req_wdata_i  = wd;
    u_bus.rsp_ready_i  = (hold == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!u_bus.req_ready_o && n < 50);
    if (!u_bus.req_ready_o) begin
      chk({name, " accept timeout"}, 32'd0, 32'd1);
      u_bus.req_valid_i = 1'b0;
      u_bus.rsp_ready_i = 1'b1;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    u_bus.req_valid_i  = 1'b0;
    u_bus.req_we_i     = 1'($urandom);
    u_bus.req_funct3_i = 3'($urandom);
    u_bus.req_addr_i   = $urandom;
    u_bus.req_wdata_i  = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!u_bus.rsp_valid_o && n < 50);
    chk({name, " latency"}, 32'(cyc - acc + 1), 32'd2);
    if (hold > 0) begin
      u_bus.req_valid_i  = 1'b1;
      u_bus.req_we_i     = 1'b1;
      u_bus.req_funct3_i = 3'd2;
      u_bus.req_addr_i   = addr;
      u_bus.req_wdata_i  = 32'hBAD0BAD0;
      repeat (hold) @(negedge clk);
      @(posedge clk); #1;
      u_bus.req_valid_i = 1'b0;
      u_bus.rsp_ready_i = 1'b1;
      @(negedge clk);
    end
    chk({name, " rdata"}, u_bus.rsp_rdata_o, exp_rd);
    chk({name, " err"}, {31'd0, u_bus.rsp_err_o}, {31'd0, exp_err});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    int n;
    u_bus.req_valid_i  = 1'b0;
    u_bus.req_we_i     = 1'b0;
    u_bus.req_funct3_i = 3'd0;
    u_bus.req_addr_i   = 32'd0;
    u_bus.req_wdata_i  = 32'd0;
    u_bus.rsp_ready_i  = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("por rsp_valid", {31'd0, u_bus.rsp_valid_o}, 32'd0);
    chk("por rsp_rdata", u_bus.rsp_rdata_o, 32'd0);
    chk("por rsp_err", {31'd0, u_bus.rsp_err_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("por req_ready", {31'd0, u_bus.req_ready_o}, 32'd1);

    txn("sw 0x000",      1'b1, 3'd2, 32'h000,  32'h11223344, 0, 32'h0, 1'b0);
    txn("sw 0x100",      1'b1, 3'd2, 32'h100,  32'hDEADBEEF, 0, 32'h0, 1'b0);
    txn("lw 0x100",      1'b0, 3'd2, 32'h100,  32'h0,        0, 32'hDEADBEEF, 1'b0);
    txn("sw 0x100 zero", 1'b1, 3'd2, 32'h100,  32'h00000000, 0, 32'h0, 1'b0);
    txn("sb 0x103",      1'b1, 3'd0, 32'h103,  32'hFFFFFF80, 0, 32'h0, 1'b0);
    txn("lb 0x103",      1'b0, 3'd0, 32'h103,  32'h0,        0, 32'hFFFFFF80, 1'b0);
    txn("lbu 0x103",     1'b0, 3'd4, 32'h103,  32'h0,        0, 32'h00000080, 1'b0);
    txn("lw after sb",   1'b0, 3'd2, 32'h100,  32'h0,        0, 32'h80000000, 1'b0);
    txn("lh 0x102",      1'b0, 3'd1, 32'h102,  32'h0,        0, 32'hFFFF8000, 1'b0);
    txn("lhu 0x102",     1'b0, 3'd5, 32'h102,  32'h0,        0, 32'h00008000, 1'b0);
    txn("sh 0x100",      1'b1, 3'd1, 32'h100,  32'hABCD1234, 0, 32'h0, 1'b0);
    txn("lw held",       1'b0, 3'd2, 32'h100,  32'h0,        5, 32'h80001234, 1'b0);
    txn("lw no intrude", 1'b0, 3'd2, 32'h100,  32'h0,        0, 32'h80001234, 1'b0);
    txn("lw oor",        1'b0, 3'd2, 32'h1000, 32'h0,        0, 32'h0, 1'b1);
    txn("sw oor",        1'b1, 3'd2, 32'h1000, 32'hFFFFFFFF, 0, 32'h0, 1'b1);
    txn("lw 0x000",      1'b0, 3'd2, 32'h000,  32'h0,        0, 32'h11223344, 1'b0);
    txn("load f3=3",     1'b0, 3'd3, 32'h100,  32'h0,        0, 32'h0, 1'b1);
    txn("store f3=4",    1'b1, 3'd4, 32'h100,  32'hFFFFFFFF, 0, 32'h0, 1'b1);
    txn("lw after bad",  1'b0, 3'd2, 32'h100,  32'h0,        0, 32'h80001234, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
    txn("lw 0x102",      1'b0, 3'd2, 32'h102,  32'h0,        0, 32'h0, 1'b1);
`else
    txn("lw 0x102",      1'b0, 3'd2, 32'h102,  32'h0,        0, 32'h80001234, 1'b0);
`endif

    // Reset while the store sits in WAIT: response dropped, store kept.
    @(posedge clk); #1;
    u_bus.req_valid_i  = 1'b1;
    u_bus.req_we_i     = 1'b1;
    u_bus.req_funct3_i = 3'd2;
    u_bus.req_addr_i   = 32'h10;
    u_bus.req_wdata_i  = 32'h12345678;
    n = 0;
    do begin @(negedge clk); n++; end while (!u_bus.req_ready_o && n < 50);
    chk("mid-reset store accepted", {31'd0, u_bus.req_ready_o}, 32'd1);
    @(posedge clk); #1;
    u_bus.req_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid-reset rsp_valid", {31'd0, u_bus.rsp_valid_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid-reset ready", {31'd0, u_bus.req_ready_o}, 32'd1);
    txn("lw 0x10",       1'b0, 3'd2, 32'h10,   32'h0,        0, 32'h12345678, 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default DATA_MEM_DEPTH, meaning number of 32-bit words (power of 2, >= 4).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning extra cycles between accept and response (legal 0..7).
REQ-003 SHALL have port clk  input  1  meaning the single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1  meaning request present.
REQ-006 SHALL have port req_ready_o  output  1  meaning controller accepts a request this cycle.
REQ-007 SHALL have port req_we_i  input  1  meaning 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3_i  input  3  meaning RV32 load/store funct3.
REQ-009 SHALL have port req_addr_i  input  DATA_WIDTH  meaning byte address.
REQ-010 SHALL have port req_wdata_i  input  DATA_WIDTH  meaning store data, right-aligned.
REQ-011 SHALL have port rsp_valid_o  output  1  meaning response present.
REQ-012 SHALL have port rsp_ready_i  input  1  meaning consumer takes the response.
REQ-013 SHALL have port rsp_rdata_o  output  DATA_WIDTH  meaning extended load data (0 for stores and errors).
REQ-014 SHALL have port rsp_err_o  output  1  meaning access fault, valid with rsp_valid_o.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT (WAIT_STATES > 0) or RESP (WAIT_STATES = 0) on req_valid_i && req_ready_o; WAIT -> RESP after WAIT_STATES cycles; RESP -> IDLE on rsp_ready_i.
REQ-016 SHALL drive req_ready_o = 1 only in IDLE; one transaction outstanding.
REQ-017 SHALL assert rsp_valid_o exactly 1 + WAIT_STATES cycles after the accept edge and hold rsp_valid_o, rsp_rdata_o, rsp_err_o stable until rsp_ready_i.
REQ-018 SHALL latch funct3, we, addr, wdata at the accept edge; inputs afterwards are ignored.
REQ-019 SHALL commit stores with byte enables at the accept edge: SB one lane per addr[1:0], SH lanes 1:0 or 3:2 per addr[1], SW all lanes; store data replicated to the selected lane(s).
REQ-020 SHALL produce loads from the memory word read in the last WAIT/accept cycle, shifted by addr[1:0]: LB/LH sign-extended, LBU/LHU zero-extended, LW unchanged.
REQ-021 SHALL flag rsp_err_o for addr >= 4*DEPTH, for funct3 not in {LB,LH,LW,LBU,LHU} on loads or {SB,SH,SW} on stores; errored stores write nothing.
REQ-022 SHALL return a load issued right after a store to the same word with the stored value (write commits before the read edge).
REQ-023 SHALL use a block RAM array, single write port, word index addr[$clog2(DEPTH)+1:2].

Reset
REQ-024 SHALL on rst_n low force IDLE, req_ready_o 1 after release, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0.
REQ-025 SHALL on reset mid-transaction drop the response; a store already committed at its accept edge remains in memory.
REQ-026 SHALL NOT reset memory contents.

Configuration
REQ-027 SHALL, with DMEM_MISALIGN_CHECK_EN defined, flag rsp_err_o and suppress the write for LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0.
REQ-028 SHALL, without DMEM_MISALIGN_CHECK_EN, ignore the misaligned low bits (halfword uses addr[1], word uses aligned word) and never flag misalignment.

Verification
REQ-029 SHALL cover: WAIT_STATES=1, SW 0x100 data 0xDEADBEEF then LW 0x100 -> rsp_rdata_o 0xDEADBEEF two cycles after each accept, rsp_err_o 0.
REQ-030 SHALL cover: SB 0x103 data 0x80 over word 0 -> LB 0x103 returns 0xFFFFFF80, LBU 0x103 returns 0x00000080, LW 0x100 returns 0x80000000.
REQ-031 SHALL cover: rsp_ready_i held low 5 cycles -> rsp_valid_o and data stable, req_ready_o 0, new req_valid_i not accepted.
REQ-032 SHALL cover: LW at 4*DEPTH -> rsp_err_o 1, rsp_rdata_o 0; SW there -> no memory word changes.
REQ-033 SHALL cover: LW 0x102 with DMEM_MISALIGN_CHECK_EN -> rsp_err_o 1; without -> word 0x100 returned, rsp_err_o 0.
REQ-034 SHALL cover: rst_n low during WAIT after SW 0x10 0x12345678 -> rsp_valid_o 0 at once, IDLE after release, LW 0x10 returns 0x12345678.
